// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and constants for the multiword add/sub sequencer.
package multiword_add_sequencer_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/multiword_add_sequencer_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module carryLookAheadAdder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Lookahead inside each 4-bit group; each group's carry-out feeds the next group.
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int gi = 0; gi < 8; gi++) begin
            c[gi*4+1] = g[gi*4] | (p[gi*4] & c[gi*4]);
            c[gi*4+2] = g[gi*4+1] | (p[gi*4+1] & g[gi*4])
                      | (p[gi*4+1] & p[gi*4] & c[gi*4]);
            c[gi*4+3] = g[gi*4+2] | (p[gi*4+2] & g[gi*4+1])
                      | (p[gi*4+2] & p[gi*4+1] & g[gi*4])
                      | (p[gi*4+2] & p[gi*4+1] & p[gi*4] & c[gi*4]);
            c[gi*4+4] = g[gi*4+3] | (p[gi*4+3] & g[gi*4+2])
                      | (p[gi*4+3] & p[gi*4+2] & g[gi*4+1])
                      | (p[gi*4+3] & p[gi*4+2] & p[gi*4+1] & g[gi*4])
                      | (p[gi*4+3] & p[gi*4+2] & p[gi*4+1] & p[gi*4] & c[gi*4]);
        end
    end

    assign sum  = p ^ c[31:0];
    assign cout = c[32];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multiword add/subtract: one 32-bit adder reused per cycle, word 0 first.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request; operands latched on accept
// RUN     | one word per cycle, carry held in carry_q between words
// DONE    | result/cout/overflow held until out_ready
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    op_sub,
    input  logic [WORD_W*WORDS-1:0] a,
    input  logic [WORD_W*WORDS-1:0] b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_W*WORDS-1:0] result,
    output logic                    cout,
    output logic                    overflow
);

    localparam int DW    = WORD_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    seq_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              op_q, op_d;
    logic [DW-1:0]     a_q, a_d;
    logic [DW-1:0]     b_q, b_d;
    logic [DW-1:0]     result_q, result_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [WORD_W-1:0] a_word;
    logic [WORD_W-1:0] b_word;
    logic [WORD_W-1:0] sum_word;
    logic              add_cin;
    logic              add_cout;
    logic              ovf_word;

    // Select the current word; subtraction is a + ~b + 1, the +1 entering as cin of word 0.
    always_comb begin
        a_word   = a_q[int'(idx_q)*WORD_W +: WORD_W];
        b_word   = b_q[int'(idx_q)*WORD_W +: WORD_W];
        if (op_q) begin
            b_word = ~b_word;
        end
        add_cin  = (idx_q == '0) ? op_q : carry_q;
        ovf_word = (a_word[WORD_W-1] == b_word[WORD_W-1])
                 && (sum_word[WORD_W-1] != a_word[WORD_W-1]);
    end

    carryLookAheadAdder u_cla (
        .a    (a_word),
        .b    (b_word),
        .cin  (add_cin),
        .sum  (sum_word),
        .cout (add_cout)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op_sub;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[int'(idx_q)*WORD_W +: WORD_W] = sum_word;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    ovf_d   = ovf_word;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer with WORDS=4.
module tb_multiword_add_sequencer;

    localparam int WORDS = 4;
    localparam int DW    = 32 * WORDS;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          op_sub;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          cout;
    logic          overflow;

    int n_checks = 0;
    int n_pass   = 0;

    multiword_add_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for out_valid; lat = edges from accept.
    task automatic start_op(input logic sub, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                            input bit scramble, output int lat);
        @(negedge clk);
        check("in_ready_before_req", {127'd0, in_ready}, 1);
        in_valid = 1'b1;
        op_sub   = sub;
        a        = av;
        b        = bv;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (scramble) begin
                a      = {$urandom, $urandom, $urandom, $urandom};
                b      = {$urandom, $urandom, $urandom, $urandom};
                op_sub = ~op_sub;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("out_valid_seen", {127'd0, out_valid}, 1);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after_handoff", {127'd0, in_ready}, 1);
        check("out_valid_after_handoff", {127'd0, out_valid}, 0);
    endtask

    task automatic run_case(input string tag, input logic sub, input logic [DW-1:0] av,
                            input logic [DW-1:0] bv, input bit scramble,
                            input logic [DW-1:0] exp_res, input logic exp_c, input logic exp_v);
        int lat;
        start_op(sub, av, bv, scramble, lat);
        check({tag, "_latency"}, DW'(lat), DW'(WORDS));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_cout"}, {127'd0, cout}, {127'd0, exp_c});
        check({tag, "_overflow"}, {127'd0, overflow}, {127'd0, exp_v});
        finish_op();
    endtask

    initial begin
        int            lat;
        logic [DW-1:0] held;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_sub    = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        #12;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", {127'd0, in_ready}, 1);
        check("reset_out_valid", {127'd0, out_valid}, 0);
        check("reset_result", result, 0);
        check("reset_cout", {127'd0, cout}, 0);
        check("reset_overflow", {127'd0, overflow}, 0);

        run_case("add_ones_plus1", 1'b0, {DW{1'b1}}, 128'd1, 1'b0, 128'd0, 1'b1, 1'b0);
        run_case("add_word_carry", 1'b0, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0,
                 128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0, 1'b0);
        run_case("sub_0_minus_1", 1'b1, 128'd0, 128'd1, 1'b0, {DW{1'b1}}, 1'b0, 1'b0);
        run_case("add_pos_ovf", 1'b0, 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
                 128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1);
        run_case("sub_neg_ovf", 1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd1, 1'b0,
                 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        run_case("add_scramble", 1'b0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                 128'h1111_1111_2222_2222_3333_3333_4444_4444, 1'b1,
                 128'h1234_5678_ABCD_F012_320F_EDCB_BA98_7654, 1'b0, 1'b0);

        // Backpressure: hold DONE with in_valid asserted and new operands presented.
        start_op(1'b0, 128'd100, 128'd23, 1'b0, lat);
        held = result;
        check("bp_result_first", held, 128'd123);
        in_valid = 1'b1;
        a        = 128'd5;
        b        = 128'd5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_result_stable", result, 128'd123);
            check("bp_out_valid", {127'd0, out_valid}, 1);
            check("bp_in_ready", {127'd0, in_ready}, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_release_in_ready", {127'd0, in_ready}, 1);
        check("bp_release_out_valid", {127'd0, out_valid}, 0);
        check("bp_no_ghost_accept", result, 128'd123);

        // Reset while the third word is being processed.
        @(negedge clk);
        in_valid = 1'b1;
        op_sub   = 1'b0;
        a        = {DW{1'b1}};
        b        = {DW{1'b1}};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_result", result, 0);
        check("rst_mid_cout", {127'd0, cout}, 0);
        check("rst_mid_overflow", {127'd0, overflow}, 0);
        check("rst_mid_out_valid", {127'd0, out_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_after_in_ready", {127'd0, in_ready}, 1);
        check("rst_after_out_valid", {127'd0, out_valid}, 0);
        run_case("post_rst_sub", 1'b1, 128'd5, 128'd3, 1'b0, 128'd2, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multiword_add_sequencer.md
MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 SHALL have parameter WORDS, default 4, number of 32-bit words per operand (legal range 1..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  sequencer can accept a request.
REQ-006 SHALL have port op_sub  input  1  0 = a+b, 1 = a-b.
REQ-007 SHALL have port a  input  32*WORDS  operand A, word 0 = bits [31:0].
REQ-008 SHALL have port b  input  32*WORDS  operand B.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  32*WORDS  sum/difference, modulo 2^(32*WORDS).
REQ-012 SHALL have port cout  output  1  carry out of top word (for sub: 1 = no borrow).
REQ-013 SHALL have port overflow  output  1  two's-complement signed overflow of full-width operation.

Function
REQ-014 SHALL compute the full-width result by one 32-bit carry-lookahead adder instance used once per cycle, word 0 first, carry registered between words.
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-016 SHALL accept a request on the edge where in_valid & in_ready; a, b, op_sub latched that edge; later input changes SHALL have no effect on the operation.
REQ-017 SHALL, for word k in RUN, feed adder a_word[k], b_word[k] (inverted when op_sub), cin = op_sub for k=0, else registered carry out of word k-1.
REQ-018 SHALL store adder sum in result word k and carry out in carry register on each RUN edge; word index counter increments 0..WORDS-1.
REQ-019 SHALL leave RUN for DONE on the edge processing word WORDS-1; out_valid first high WORDS cycles after the accept edge (WORDS=1: one cycle).
REQ-020 SHALL take cout and overflow from the adder on the word WORDS-1 cycle (overflow evaluated on the inverted b word when op_sub).
REQ-021 SHALL hold result, cout, overflow and out_valid stable in DONE while out_ready is low.
REQ-022 SHALL return to IDLE on the edge where out_valid & out_ready; in_ready high the following cycle (no accept in the same edge as result handoff).
REQ-023 SHALL ignore in_valid outside IDLE; out_ready outside DONE SHALL have no effect.

Reset
REQ-024 SHALL, on rst_n low at any time (including mid-RUN), asynchronously force IDLE, clear word index, carry register, result, cout, overflow to 0; in-flight operation discarded.
REQ-025 SHALL have in_ready = 1, out_valid = 0 immediately after reset deassertion.

Structure
REQ-026 SHALL place FSM state encoding (IDLE, RUN, DONE) and word width constant 32 in a shared package.
REQ-027 SHALL instantiate the existing 32-bit carry-lookahead adder (carryLookAheadAdder) as its single sub-module; no second adder.

Verification
REQ-028 Add, WORDS=4: a=all ones, b=1 -> result=0, cout=1, overflow=0, out_valid 4 cycles after accept.
REQ-029 Add: a=0x...0000_FFFFFFFF, b=1 -> result=0x...0001_00000000, cout=0 (carry crosses word boundary).
REQ-030 Sub: a=0, b=1 -> result=all ones, cout=0, overflow=0; a=0x7FFF..FF, op add, b=1 -> result=0x8000..00, overflow=1.
REQ-031 Backpressure: out_ready low 5 cycles in DONE -> outputs stable, in_ready low, in_valid ignored; out_ready high -> IDLE next edge.
REQ-032 Reset asserted in RUN at word 2 -> all outputs 0, in_ready=1 after deassert; next request completes correctly.
REQ-033 Inputs a/b changed every cycle during RUN -> result matches operands latched at accept.
